pat_gen: RTL and testbench
==========================

Name: pat_gen

Overview:
Serial pattern generator: the transmit-side counterpart of the team's serial pattern detector. It loads a DATA_W-bit word in parallel and shifts it out MSB first, one bit per DIV clock cycles, with a load/busy/done handshake. It also runs a built-in PAT_W-bit matcher on the emitted stream, giving the bench a golden pat_hit to compare against the detector in loopback.

Parameters:
DATA_W, 32, frame length in bits (>= PAT_W)
PAT_W, 4, pattern width for the companion matcher
DIV, 4, clk cycles per serial bit (>= 2); counter width = $clog2(DIV)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
load  input  1  one-cycle request; starts a frame when idle
data_in  input  DATA_W  word to transmit, sampled on accepted load
pattern  input  PAT_W  match pattern, sampled on accepted load
ser_out  output  1  serial data, MSB first; 0 when idle
bit_valid  output  1  one-cycle strobe in the first cycle of each bit period
busy  output  1  high while a frame is in progress
done  output  1  one-cycle pulse after the last bit period
pat_hit  output  1  high for the whole bit period when the last PAT_W emitted bits equal pattern

Behaviour:
- Reset (sync, sampled on clk edge): state=IDLE; ser_out=0, bit_valid=0, busy=0, done=0, pat_hit=0; shift reg, bit index, divider, history cleared. Reset wins over every other input and aborts a frame mid-stream with no done pulse.
- FSM states: IDLE, SHIFT.
- IDLE: load=1 at edge T -> at T+1: state=SHIFT, busy=1, ser_out=data_in[DATA_W-1], bit_valid=1, div_cnt=0, bit_idx=DATA_W-1, pattern latched, history cleared then bit shifted in.
- SHIFT: div_cnt increments every cycle; bit_valid=0 except the first cycle of a period. When div_cnt==DIV-1 and bit_idx>0: div_cnt=0, shift left, ser_out = next bit, bit_idx-1, bit_valid=1.
- Last period end (div_cnt==DIV-1, bit_idx==0): next cycle state=IDLE, busy=0, done=1 (one cycle), ser_out=0, pat_hit=0.
- busy is high for exactly DATA_W*DIV cycles per frame.
- load while busy=1 is ignored; data_in/pattern changes mid-frame have no effect.
- load in the cycle done=1 (IDLE) is accepted -> minimum inter-frame gap of one idle cycle.
- Matcher: history is a PAT_W-bit shift register fed with each emitted bit at its bit_valid cycle. pat_hit is registered and valid from that same cycle through the end of the period. pat_hit=1 iff history==latched pattern and at least PAT_W bits have been emitted in this frame. No match may span two frames.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package: state enum (IDLE, SHIFT) and the default DIV/DATA_W/PAT_W constants shared with the detector bench.
- One sub-module, bit_tick_gen: a DIV-cycle counter with a synchronous clear. It outputs period_start and period_end strobes. The FSM, shift register and matcher stay in pat_gen.

Test Plan:
- Reset then idle 20 cycles -> ser_out, busy, done, bit_valid and pat_hit all 0. load while reset=1 -> no frame starts.
- DIV=4, data_in=32'h66DF18D6, pattern=4'b0110, load at T -> busy high T+1..T+128. ser_out per 4-cycle period = 0110_0110_1101_1111_0001_1000_1101_0110. Exactly 32 bit_valid strobes. done=1 at T+129 only.
- Same frame -> pat_hit asserted in exactly 6 bit periods (bit indices 3, 7, 10, 21, 26, 31 counted from 0 at the MSB), each lasting 4 cycles. It matches the serial detector's output bit-for-bit in loopback.
- load pulsed at T+50 with data_in=32'hFFFFFFFF mid-frame -> ignored; the stream is unchanged. load at the done cycle with 32'h80000001 -> new frame starts next cycle. ser_out=1 for the first period, 0 for 30 periods, then 1 for the last period.
- reset asserted at T+60 mid-frame -> all outputs 0 the next cycle, no done pulse. A following load transmits cleanly from the MSB.
- pattern=4'b0000, data=32'h00000000 -> pat_hit low for bits 0-2 and high from bit 3 to the end of the frame. Low in the done cycle. The next frame's first three bits give no hit, proving no cross-frame match.

Source files
------------

// File: rtl/pat_gen_pkg.sv
// Shared types and default sizing for the serial pattern generator and its detector bench.
package pat_gen_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_PAT_W  = 4;
  localparam int DEF_DIV    = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/pat_gen_if.sv
// Load/stream bus of the pattern generator; master drives the request, slave is the generator.
interface pat_gen_if
  import pat_gen_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int PAT_W  = DEF_PAT_W
) ();

  logic              load;
  logic [DATA_W-1:0] data_in;
  logic [PAT_W-1:0]  pattern;
  logic              ser_out;
  logic              bit_valid;
  logic              busy;
  logic              done;
  logic              pat_hit;

  modport master (
    output load, data_in, pattern,
    input  ser_out, bit_valid, busy, done, pat_hit
  );

  modport slave (
    input  load, data_in, pattern,
    output ser_out, bit_valid, busy, done, pat_hit
  );

endinterface

// File: rtl/pat_gen_bit_tick_gen.sv
// DIV-cycle bit-period counter; period_start flags the edge that opens a new period.
module bit_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic period_start,
  output logic period_end
);

  localparam int                CNT_W    = $clog2(DIV);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_r;

  assign period_end   = enable && (cnt_r == CNT_LAST);
  assign period_start = clear || period_end;

  // Divider counter: restarts on clear or at the end of each period.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (period_start) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (enable) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/pat_gen.sv
// Serial pattern generator: shifts a loaded word out MSB first, one bit per DIV clocks,
// and flags bit periods where the last PAT_W emitted bits equal the latched pattern.
module pat_gen
  import pat_gen_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int PAT_W  = DEF_PAT_W,
  parameter int DIV    = DEF_DIV
) (
  input  logic     clk,
  input  logic     reset,
  pat_gen_if.slave bus
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam int NB_W  = $clog2(PAT_W + 1);

  state_t              state_r, state_s;
  // The MSB is already on ser_out, so only the remaining DATA_W-1 bits are held.
  logic [DATA_W-2:0]   shift_r, shift_s;
  logic [IDX_W-1:0]    bit_idx_r, bit_idx_s;
  logic [PAT_W-1:0]    hist_r, hist_s;
  logic [PAT_W-1:0]    pat_r, pat_s;
  logic [NB_W-1:0]     nbits_r, nbits_s;
  logic                ser_out_r, ser_out_s;
  logic                bit_valid_r, bit_valid_s;
  logic                busy_r, busy_s;
  logic                done_r, done_s;
  logic                pat_hit_r, pat_hit_s;

  logic                accept_s, advance_s, finish_s, next_bit_s;
  logic                tick_en_s, period_start_s, period_end_s;

  assign tick_en_s  = (state_r == ST_SHIFT);
  assign accept_s   = (state_r == ST_IDLE) && bus.load;
  assign advance_s  = period_end_s && (bit_idx_r != {IDX_W{1'b0}});
  assign finish_s   = period_end_s && (bit_idx_r == {IDX_W{1'b0}});
  assign next_bit_s = shift_r[DATA_W-2];

  bit_tick_gen #(.DIV(DIV)) u_tick (
    .clk          (clk),
    .reset        (reset),
    .clear        (accept_s),
    .enable       (tick_en_s),
    .period_start (period_start_s),
    .period_end   (period_end_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_s = ST_SHIFT;
        else          state_s = ST_IDLE;
      end
      ST_SHIFT: begin
        if (finish_s) state_s = ST_IDLE;
        else          state_s = ST_SHIFT;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Next values of the datapath and of every registered output.
  always_comb begin
    shift_s   = shift_r;
    bit_idx_s = bit_idx_r;
    hist_s    = hist_r;
    pat_s     = pat_r;
    nbits_s   = nbits_r;
    ser_out_s = ser_out_r;
    busy_s    = busy_r;
    done_s    = 1'b0;
    if (accept_s) begin
      shift_s   = bus.data_in[DATA_W-2:0];
      bit_idx_s = IDX_W'(DATA_W - 1);
      hist_s    = {{(PAT_W-1){1'b0}}, bus.data_in[DATA_W-1]};
      pat_s     = bus.pattern;
      nbits_s   = NB_W'(1);
      ser_out_s = bus.data_in[DATA_W-1];
      busy_s    = 1'b1;
    end else if (advance_s) begin
      shift_s   = {shift_r[DATA_W-3:0], 1'b0};
      bit_idx_s = bit_idx_r - IDX_W'(1);
      hist_s    = {hist_r[PAT_W-2:0], next_bit_s};
      if (nbits_r == NB_W'(PAT_W)) nbits_s = nbits_r;
      else                         nbits_s = nbits_r + NB_W'(1);
      ser_out_s = next_bit_s;
    end else if (finish_s) begin
      shift_s   = {(DATA_W-1){1'b0}};
      bit_idx_s = {IDX_W{1'b0}};
      hist_s    = {PAT_W{1'b0}};
      nbits_s   = {NB_W{1'b0}};
      ser_out_s = 1'b0;
      busy_s    = 1'b0;
      done_s    = 1'b1;
    end else begin
      done_s    = 1'b0;
    end

    bit_valid_s = period_start_s && (state_s == ST_SHIFT);

    // The hit is decided once per bit and then held for the whole period.
    if (accept_s || advance_s) begin
      pat_hit_s = (nbits_s == NB_W'(PAT_W)) && (hist_s == pat_s);
    end else if (finish_s) begin
      pat_hit_s = 1'b0;
    end else begin
      pat_hit_s = pat_hit_r;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_r     <= {(DATA_W-1){1'b0}};
      bit_idx_r   <= {IDX_W{1'b0}};
      hist_r      <= {PAT_W{1'b0}};
      pat_r       <= {PAT_W{1'b0}};
      nbits_r     <= {NB_W{1'b0}};
      ser_out_r   <= 1'b0;
      bit_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pat_hit_r   <= 1'b0;
    end else begin
      shift_r     <= shift_s;
      bit_idx_r   <= bit_idx_s;
      hist_r      <= hist_s;
      pat_r       <= pat_s;
      nbits_r     <= nbits_s;
      ser_out_r   <= ser_out_s;
      bit_valid_r <= bit_valid_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      pat_hit_r   <= pat_hit_s;
    end
  end

  assign bus.ser_out   = ser_out_r;
  assign bus.bit_valid = bit_valid_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.pat_hit   = pat_hit_r;

endmodule

// File: tb/tb_pat_gen.sv
// Scoreboard bench for pat_gen: expected bits/hits are queued at stimulus time and
// checked by an independent monitor on every bit strobe, hold cycle and done pulse.
module tb_pat_gen;
  import pat_gen_pkg::*;

  localparam int DW = 32;
  localparam int PW = 4;
  localparam int DV = 4;
  localparam int FRAME_CYC = DW * DV;

  typedef struct packed {
    logic ser;
    logic hit;
  } bit_exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pat_gen_if #(.DATA_W(DW), .PAT_W(PW)) bus ();

  pat_gen #(.DATA_W(DW), .PAT_W(PW), .DIV(DV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  bit_exp_t bq[$];
  int       fq[$];
  int       n_checks = 0;
  int       n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // hits is MSB-aligned like data: bit (31-i) set means a hit in bit period i.
  task automatic push_frame(input logic [31:0] data, input logic [31:0] hits,
                            input int nbits, input bit with_done);
    bit_exp_t e;
    for (int i = 0; i < nbits; i++) begin
      e.ser = data[31-i];
      e.hit = hits[31-i];
      bq.push_back(e);
    end
    if (with_done) fq.push_back(nbits);
  endtask

  task automatic issue(input logic [31:0] data, input logic [3:0] pat);
    bus.data_in = data;
    bus.pattern = pat;
    bus.load    = 1'b1;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int c = 0; c < FRAME_CYC + 20; c++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  // Monitor: pops one expectation per bit strobe and audits each frame at done.
  initial begin
    bit_exp_t cur;
    bit       have_cur = 1'b0;
    int       busy_cnt = 0;
    int       bv_cnt = 0;
    int       exp_bits;
    logic     prev_busy = 1'b0;
    cur = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy_cnt = 0; bv_cnt = 0; have_cur = 1'b0; prev_busy = 1'b0;
      end else begin
        if (bus.bit_valid) begin
          if (bq.size() == 0) begin
            check("unexpected_bit_valid", 32'(bus.bit_valid), 32'd0);
          end else begin
            cur = bq.pop_front();
            have_cur = 1'b1;
            bv_cnt++;
            check("bit_ser", 32'(bus.ser_out), 32'(cur.ser));
            check("bit_hit", 32'(bus.pat_hit), 32'(cur.hit));
            check("bit_busy", 32'(bus.busy), 32'd1);
          end
        end else if (bus.busy && have_cur) begin
          check("hold_ser", 32'(bus.ser_out), 32'(cur.ser));
          check("hold_hit", 32'(bus.pat_hit), 32'(cur.hit));
        end
        if (bus.busy) busy_cnt++;
        if (bus.done) begin
          if (fq.size() == 0) begin
            check("unexpected_done", 32'(bus.done), 32'd0);
          end else begin
            exp_bits = fq.pop_front();
            check("frame_busy_cycles", 32'(busy_cnt), 32'(exp_bits * DV));
            check("frame_bit_strobes", 32'(bv_cnt), 32'(exp_bits));
            check("done_after_busy", 32'(prev_busy), 32'd1);
            check("done_outputs", 32'({bus.busy, bus.ser_out, bus.pat_hit, bus.bit_valid}), 32'd0);
          end
          busy_cnt = 0; bv_cnt = 0; have_cur = 1'b0;
        end else if (!bus.busy) begin
          check("idle_outputs", 32'({bus.ser_out, bus.pat_hit, bus.bit_valid}), 32'd0);
        end
        prev_busy = bus.busy;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit, expected end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.load    = 1'b0;
    bus.data_in = 32'h0000_0000;
    bus.pattern = 4'h0;
    reset       = 1'b1;

    // Load during reset must not start a frame.
    repeat (2) @(posedge clk);
    #1 issue(32'h1234_5678, 4'h5);
    @(posedge clk);
    #1 bus.load = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_after_reset",
            32'({bus.busy, bus.done, bus.bit_valid, bus.ser_out, bus.pat_hit}), 32'd0);
    end

    // Frame A; hits at bit periods 3,7,10,21,26,31.
    push_frame(32'h66DF_18D6, 32'h1120_0421, 32, 1'b1);
    issue(32'h66DF_18D6, 4'b0110);
    @(posedge clk);
    #1 bus.load = 1'b0;
    @(negedge clk);
    check("A_first_strobe", 32'({bus.busy, bus.bit_valid, bus.ser_out}), 32'b110);
    for (int c = 1; c <= FRAME_CYC; c++) begin
      @(posedge clk);
      if (c == 49) #1 issue(32'hFFFF_FFFF, 4'b1111);
      if (c == 50) #1 bus.load = 1'b0;
      @(negedge clk);
      if (c == FRAME_CYC - 1) check("A_busy_last", 32'({bus.busy, bus.done}), 32'b10);
      if (c == FRAME_CYC)     check("A_done_cycle", 32'({bus.busy, bus.done}), 32'b01);
    end

    // Frame B loaded in the done cycle; hits at periods 4..30.
    push_frame(32'h8000_0001, 32'h0FFF_FFFE, 32, 1'b1);
    issue(32'h8000_0001, 4'b0000);
    @(posedge clk);
    #1 bus.load = 1'b0;
    @(negedge clk);
    check("B_starts_next_cycle", 32'({bus.busy, bus.bit_valid, bus.ser_out}), 32'b111);
    wait_done("B");
    repeat (3) @(negedge clk);

    // Frame C aborted by reset after 60 busy cycles (15 bit periods).
    push_frame(32'hF0F0_F0F0, 32'h1010_1010, 15, 1'b0);
    issue(32'hF0F0_F0F0, 4'b1111);
    @(posedge clk);
    #1 bus.load = 1'b0;
    repeat (59) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("C_reset_clears",
          32'({bus.busy, bus.done, bus.bit_valid, bus.ser_out, bus.pat_hit}), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    check("C_queue_drained", 32'(bq.size()), 32'd0);
    repeat (2) @(negedge clk);

    // Frame D: clean transmission after the abort.
    push_frame(32'hF0F0_F0F0, 32'h1010_1010, 32, 1'b1);
    issue(32'hF0F0_F0F0, 4'b1111);
    @(posedge clk);
    #1 bus.load = 1'b0;
    wait_done("D");
    repeat (2) @(negedge clk);

    // Frames E and F: all-zero data and pattern, back to back; hits from period 3 on.
    push_frame(32'h0000_0000, 32'h1FFF_FFFF, 32, 1'b1);
    issue(32'h0000_0000, 4'b0000);
    @(posedge clk);
    #1 bus.load = 1'b0;
    wait_done("E");
    push_frame(32'h0000_0000, 32'h1FFF_FFFF, 32, 1'b1);
    issue(32'h0000_0000, 4'b0000);
    @(posedge clk);
    #1 bus.load = 1'b0;
    wait_done("F");

    repeat (4) @(negedge clk);
    check("bit_queue_empty", 32'(bq.size()), 32'd0);
    check("frame_queue_empty", 32'(fq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
